// File: rtl/packet_link_arbiter_if.sv
// Bundle of the arbiter's requester-side and link-side signals.
// The arbiter connects through the slave modport; the packetizers and link use master.
interface packet_link_arbiter_if #(
  parameter int N_REQ        = 4,
  parameter int REQ_LOG      = 2,
  parameter int PACKET_WIDTH = 16
);

  logic [N_REQ-1:0]              req_i;
  logic [N_REQ-1:0]              lock_i;
  logic [N_REQ*PACKET_WIDTH-1:0] packet_i;
  logic                          link_ready_i;
  logic [N_REQ-1:0]              grant_o;
  logic                          link_valid_o;
  logic [PACKET_WIDTH-1:0]       link_packet_o;
  logic [REQ_LOG-1:0]            owner_o;
  logic                          timeout_o;
  logic [REQ_LOG-1:0]            timeout_id_o;

  modport master (
    output req_i, lock_i, packet_i, link_ready_i,
    input  grant_o, link_valid_o, link_packet_o, owner_o, timeout_o, timeout_id_o
  );

  modport slave (
    input  req_i, lock_i, packet_i, link_ready_i,
    output grant_o, link_valid_o, link_packet_o, owner_o, timeout_o, timeout_id_o
  );

endinterface

// File: rtl/packet_link_arbiter.sv
// Round-robin arbiter sharing one serial packet link among N_REQ packetizers,
// with lock-held transactions, a one-cycle guard gap and a sticky watchdog.
module packet_link_arbiter #(
  parameter int N_REQ        = 4,
  parameter int REQ_LOG      = 2,
  parameter int PACKET_WIDTH = 16,
  parameter int MAX_BEATS    = 64,
  parameter int BEAT_BITS    = 7
) (
  input logic                 clk_packet,
  input logic                 rst_n,
  packet_link_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [BEAT_BITS-1:0] BEAT_MAX = BEAT_BITS'(MAX_BEATS);
  localparam logic [REQ_LOG-1:0]   LAST_IDX = REQ_LOG'(N_REQ - 1);
  localparam logic [REQ_LOG:0]     N_WIDE   = (REQ_LOG+1)'(N_REQ);

  // First set request at or above ptr, wrapping; the doubled vector makes the
  // wrap a plain shift so the search is a fixed priority encode.
  function automatic logic [REQ_LOG-1:0] rr_pick(
    input logic [N_REQ-1:0]   req,
    input logic [REQ_LOG-1:0] ptr
  );
    logic [2*N_REQ-1:0] rot;
    logic [REQ_LOG:0]   sum;
    rot = {req, req} >> ptr;
    sum = {1'b0, ptr};
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) sum = {1'b0, ptr} + (REQ_LOG+1)'(j);
    end
    if (sum >= N_WIDE) sum = sum - N_WIDE;
    return sum[REQ_LOG-1:0];
  endfunction

  state_t                  state_q, state_d;
  logic [N_REQ-1:0]        grant_q, grant_d;
  logic [REQ_LOG-1:0]      owner_q, owner_d;
  logic [REQ_LOG-1:0]      ptr_q, ptr_d;
  logic [BEAT_BITS-1:0]    beats_q, beats_d;
  logic                    timeout_q, timeout_d;
  logic [REQ_LOG-1:0]      timeout_id_q, timeout_id_d;

  logic [PACKET_WIDTH-1:0] owner_pkt;
  logic                    owner_lock;
  logic                    busy;

  always_comb begin
    owner_pkt  = '0;
    owner_lock = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (owner_q == REQ_LOG'(k)) begin
        owner_pkt  = bus.packet_i[k*PACKET_WIDTH +: PACKET_WIDTH];
        owner_lock = bus.lock_i[k];
      end
    end
  end

  always_ff @(posedge clk_packet or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      ptr_q        <= '0;
      beats_q      <= '0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      beats_q      <= beats_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    beats_d      = beats_q;
    timeout_d    = timeout_q;
    timeout_id_d = timeout_id_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.link_ready_i && (|bus.req_i)) begin
          owner_d = rr_pick(bus.req_i, ptr_q);
          grant_d = N_REQ'(1) << owner_d;
          beats_d = BEAT_BITS'(1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A lock drop wins over a coincident watchdog expiry: no timeout is logged.
        if (!owner_lock || (beats_q == BEAT_MAX)) begin
          grant_d = '0;
          state_d = ST_GAP;
          ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + REQ_LOG'(1);
          if (owner_lock && !timeout_q) begin
            timeout_d    = 1'b1;
            timeout_id_d = owner_q;
          end
        end else begin
          beats_d = beats_q + BEAT_BITS'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign busy              = (state_q == ST_BUSY);
  assign bus.grant_o       = grant_q;
  assign bus.link_valid_o  = busy;
  assign bus.link_packet_o = busy ? owner_pkt : '0;
  assign bus.owner_o       = owner_q;
  assign bus.timeout_o     = timeout_q;
  assign bus.timeout_id_o  = timeout_id_q;

  a_grant_onehot: assert property (@(posedge clk_packet) disable iff (!rst_n)
    $onehot0(grant_q));
  a_grant_only_busy: assert property (@(posedge clk_packet) disable iff (!rst_n)
    ((grant_q != '0) == busy));

endmodule

// File: doc/packet_link_arbiter.md
Name: packet_link_arbiter

Overview:
- Shares one serial packet link among N_REQ packetizers, for example the instruction-fetch, data-cache and writeback packetizers feeding the L2 serdes.
- Arbitrates round-robin and holds the grant for a whole transaction while the owner's lock is high.
- Muxes the owner's packet stream onto the link and inserts a guard cycle between transactions.
- Includes a watchdog that cuts off a requester holding the link too long.

Parameters:
- N_REQ, 4, number of requesting packetizers (2..8).
- REQ_LOG, 2, clog2(N_REQ); width of owner and id fields.
- PACKET_WIDTH, 16, link packet width.
- MAX_BEATS, 64, maximum BUSY cycles per transaction before the watchdog fires (must be ≥ longest transaction length + 1).
- BEAT_BITS, 7, counter width; must hold MAX_BEATS.

Ports:
- clk_packet  in  1  link clock; all logic single-clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_i  in  N_REQ  per-requester packet_req.
- lock_i  in  N_REQ  per-requester lock; a held lock keeps the grant.
- packet_i  in  N_REQ*PACKET_WIDTH  per-requester packets; requester k occupies bits [k*PACKET_WIDTH +: PACKET_WIDTH].
- grant_o  out  N_REQ  one-hot registered grant.
- link_ready_i  in  1  link can accept a new transaction; sampled only in IDLE.
- link_valid_o  out  1  link_packet_o carries owner data.
- link_packet_o  out  PACKET_WIDTH  muxed packet.
- owner_o  out  REQ_LOG  current or last owner index.
- timeout_o  out  1  sticky watchdog flag.
- timeout_id_o  out  REQ_LOG  requester that caused the first timeout.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, grant_o=0, link_valid_o=0, link_packet_o=0.
  - owner_o=0, rr pointer=0, beat count=0, timeout_o=0, timeout_id_o=0.
  - Reset mid-transaction drops the grant immediately, with no tail cycle.
- States: IDLE, BUSY, GAP.
- IDLE:
  - If link_ready_i=1 and req_i≠0, choose the winner: the first set bit of req_i scanning from the rr pointer upward, with wrap-around.
  - At the clock edge: grant_o=onehot(winner), owner_o=winner, beat count=1, state→BUSY.
  - If link_ready_i=0 or req_i=0, remain in IDLE.
- Grant latency: exactly 1 cycle from sampled req to grant_o high.
- BUSY:
  - link_valid_o=1; link_packet_o=packet_i[owner] combinationally, with zero added latency.
  - Grant stays asserted while lock_i[owner]=1.
  - The lock of a non-owner and req_i changes from others are ignored.
- BUSY exit, normal: if lock_i[owner]=0 in a BUSY cycle, that cycle's packet is still forwarded (last beat). Next edge: grant_o=0, state→GAP, rr pointer=(owner+1) mod N_REQ.
- BUSY exit, watchdog: if lock_i[owner]=1 and beat count=MAX_BEATS, the same exit is taken. Additionally, if timeout_o=0: timeout_o←1 and timeout_id_o←owner. Later timeouts do not overwrite; timeout_o clears only on reset.
- Beat count: increments each BUSY cycle and saturates at MAX_BEATS; it never wraps.
- GAP:
  - Exactly one cycle; link_valid_o=0, link_packet_o=0, grant_o=0, no arbitration.
  - Next edge: state→IDLE.
  - Minimum spacing between the last beat of one transaction and the next grant is therefore 2 cycles (GAP, then IDLE sample).
- Outside BUSY, link_packet_o=0 and link_valid_o=0.
- owner_o holds its value outside BUSY.
- grant_o is never more than one-hot; it is zero in IDLE and GAP.
- A requester whose req drops while in IDLE before the sample is simply not considered. No starvation: every requester is granted within N_REQ transactions while it keeps requesting.
- Simultaneous lock drop and watchdog expiry: treat as a normal exit; timeout_o is not set.

Test Plan:
- Reset then req_i=4'b0001, link_ready_i=1:
  - grant_o=0001 one cycle later.
  - Lock held for 34 cycles (17 packets×2 example): link_packet_o equals packet_i[0] every BUSY cycle.
  - Lock drop gives one GAP cycle, then IDLE.
  - owner_o=0; rr pointer becomes 1.
- req_i=4'b1111 held continuously, each transaction 5 beats: grant order 0,1,2,3,0. Each grant rises exactly 2 cycles after the previous owner's last beat.
- Requester 2 owns the link; requester 0 raises req and toggles lock mid-transaction: grant stays 0100 and the link carries only packet_i[2].
- link_ready_i=0 with req_i=0010: no grant, link_valid_o=0. Raise link_ready_i: grant_o=0010 on the next cycle.
- MAX_BEATS=8, requester 3 holds lock indefinitely:
  - Grant drops after 8 BUSY cycles; timeout_o=1, timeout_id_o=3.
  - A later timeout by requester 1 leaves timeout_id_o=3.
  - Requester 0 is served next.
- rst_n pulsed low during BUSY: grant_o, link_valid_o and link_packet_o go 0 asynchronously. After release, the first grant goes to the lowest requesting index (rr pointer=0).
